// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: byte FIFO feeding a start/data/parity/stop serialiser.
// Optional line-break control is compiled in when UART_TX_BREAK_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BIT   = 8,
  parameter int PARITY_BIT = 0,
  parameter int STOP_BIT   = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    data_in,
  input  logic                          write_en,
`ifdef UART_TX_BREAK_EN
  input  logic                          send_break,
`endif
  output logic                          write_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_busy,
  output logic                          tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(BAUD_DIV);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be >= 2");
  end
  if (DATA_BIT < 5 || DATA_BIT > 8) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BIT must be 5..8");
  end
  if (PARITY_BIT < 0 || PARITY_BIT > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY_BIT must be 0, 1 or 2");
  end
  if (STOP_BIT < 1 || STOP_BIT > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BIT must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic                stop_q, stop_d;
  logic                tx_q, tx_d;
  logic [DATA_BIT-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;
  logic [DATA_BIT-1:0] mem_q [FIFO_DEPTH];

  logic full, empty, wr_acc, pop, tick, brk;
  logic [DATA_BIT-1:0] head;
  logic unused_data;

  assign unused_data = ^data_in;

`ifdef UART_TX_BREAK_EN
  assign brk = send_break;
`else
  assign brk = 1'b0;
`endif

  always_comb begin
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    empty    = (count_q == '0);
    wr_acc   = write_en && !full;
    head     = mem_q[rd_ptr_q];
    tick     = (cnt_q == CW'(BAUD_DIV - 1));
    pop      = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    shift_d  = shift_q;
    par_d    = par_q;

    if (state_q != S_IDLE && state_q != S_BREAK)
      cnt_d = tick ? '0 : cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (brk) begin
          state_d = S_BREAK;
          tx_d    = 1'b0;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'(DATA_BIT - 1)) begin
            if (PARITY_BIT != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              stop_d  = 1'b0;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_q == 1'(STOP_BIT - 1)) begin
            if (brk) begin
              state_d = S_BREAK;
              tx_d    = 1'b0;
            end else if (!empty) begin
              pop     = 1'b1;
              state_d = S_START;
              tx_d    = 1'b0;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = stop_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        // Leaving break: one full mark period before the next start bit.
        if (!brk) begin
          state_d = S_STOP;
          stop_d  = 1'(STOP_BIT - 1);
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      shift_d = head;
      par_d   = (^head) ^ (PARITY_BIT == 1);
      cnt_d   = '0;
    end

    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (wr_acc) mem_q[wr_ptr_q] <= data_in[DATA_BIT-1:0];
  end

  assign write_busy = full;
  assign fifo_count = count_q;
  assign tx_busy    = (state_q != S_IDLE) || !empty || brk;
  assign tx         = tx_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Standalone buffered UART transmitter: host writes bytes into an internal FIFO, block serialises them onto tx as start / data / optional parity / stop frames.
Complements the existing 16x-oversampling receiver path; implements the DATA_BIT, PARITY_BIT and STOP_BIT framing options in hardware.
Sits between a CPU/bus write port and the board TX pin.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz
BAUD_RATE, 115200, line rate in bps; BAUD_DIV = CLK_FREQ / BAUD_RATE (integer truncation, must be >= 2)
DATA_BIT, 8, data bits per frame, legal 5..8; data_in[DATA_BIT-1:0] sent, upper bits ignored
PARITY_BIT, 0, 0 = none, 1 = odd, 2 = even
STOP_BIT, 1, stop bits, legal 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of 2, >= 2

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  8  byte to enqueue
write_en  input  1  enqueue strobe, one byte per cycle while high
write_busy  output  1  FIFO full; a write_en in this cycle is dropped
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries currently queued
tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty
tx  output  1  serial line, idle high

Behaviour:
- Reset (async assert, sync release): tx=1, write_busy=0, fifo_count=0, tx_busy=0, FSM=IDLE, baud counter=0, FIFO pointers=0. Reset mid-frame aborts the frame immediately (tx=1 on assertion); the FIFO is emptied.
- FIFO: write accepted when write_en && !full, where full is evaluated before any same-cycle pop. Write on full is dropped, even if a pop occurs that cycle. Simultaneous accepted write and pop leave fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH. write_busy = (fifo_count == FIFO_DEPTH).
- Baud timing: counter runs only outside IDLE. It is loaded with 0 on frame start and counts 0..BAUD_DIV-1. Each bit period is exactly BAUD_DIV clocks; bit advance occurs when counter == BAUD_DIV-1.
- FSM states:
  - IDLE: if FIFO non-empty, pop head into shift register, compute parity, go to START. tx=1.
  - START: tx=0 for one bit period, then go to DATA.
  - DATA: tx = shift[0], LSB first; shift right each period. After DATA_BIT periods go to PARITY if PARITY_BIT != 0, else STOP.
  - PARITY: tx = XOR of data bits (even) or its inverse (odd), one period, then STOP.
  - STOP: tx=1 for STOP_BIT periods. At the end: if FIFO non-empty, pop and go directly to START (frames back-to-back, no idle clock); else go to IDLE.
- Latency: write_en at cycle N into an empty FIFO with the FSM idle -> entry visible at N+1 -> popped at N+1 -> tx falls at edge N+2.
- Frame length = BAUD_DIV * (1 + DATA_BIT + (PARITY_BIT != 0) + STOP_BIT) clocks.
- tx is driven directly from a flop (glitch-free).
- tx_busy = (FSM != IDLE) || (fifo_count != 0).
- Illegal parameter values: elaboration-time error via a generate-block check.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input send_break (1 bit). When send_break is high and the FSM is in IDLE or at a frame boundary (end of STOP), tx is forced to 0 and no pop occurs. A frame in progress completes normally first. Deasserting send_break returns tx to 1 and resumes draining the FIFO. tx_busy is high while break is held.
- Undefined: no send_break port; behaviour as above.

Test Plan:
All scenarios use CLK_FREQ=1000000, BAUD_RATE=100000 (BAUD_DIV=10) unless noted.
- 8N1, write 0x55 once -> tx low 10 clks; then bits 1,0,1,0,1,0,1,0 at 10 clks each; then high 10 clks. Frame 100 clks; tx falls 2 clks after write_en; tx_busy clears on the frame end.
- PARITY_BIT=2, STOP_BIT=2, write 0x07 -> data 1,1,1,0,0,0,0,0, parity=1, two stop bits; frame 120 clks. Repeat with PARITY_BIT=1 -> parity=0.
- DATA_BIT=5, write 0xFF -> 5 data ones only, frame 70 clks; upper bits never appear.
- Burst of 17 writes 0x00..0x10 on consecutive cycles -> first pops at once; bytes 0x01..0x10 fill the FIFO (write_busy=1, fifo_count=16). A further write of 0xAA while full is dropped. Line shows 0x00..0x10 back-to-back, no gap between stop and next start.
- rst_n low at clock 45 of a frame -> tx=1 asynchronously, fifo_count=0, tx_busy=0; after release no residual frame is sent.
- UART_TX_BREAK_EN: send_break high during byte 0x33 -> 0x33 completes, then tx=0 while held. Release -> tx=1, next queued byte sent.
